cmp_flag_pipe: RTL and testbench

- Parametrised, pipelined successor to the processor's single-cycle compare/flag logic.
- Evaluates CMP, CMN, TST and TEQ on WIDTH-bit operands and produces registered NZCV flags.
- Also evaluates a 4-bit condition code against the new flags.
- Sits between decode/operand fetch and the branch/conditional-execute logic; valid/ready handshake on both sides.

---
 rtl/cmp_flag_if.sv | 27 ++
 rtl/cmp_flag_pipe.sv | 82 ++++++++
 tb/tb_cmp_flag_pipe.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_flag_if.sv
// cmp_flag_if: operand-in / flags-out valid-ready bundle for cmp_flag_pipe.
interface cmp_flag_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       cond;
  logic             out_valid;
  logic             out_ready;
  logic             n;
  logic             z;
  logic             c;
  logic             v;
  logic [WIDTH-1:0] result;
  logic             cond_pass;
  modport master (
    output in_valid, op, a, b, cond, out_ready,
    input  in_ready, out_valid, n, z, c, v, result, cond_pass
  );
  modport slave (
    input  in_valid, op, a, b, cond, out_ready,
    output in_ready, out_valid, n, z, c, v, result, cond_pass
  );
endinterface

// File: rtl/cmp_flag_pipe.sv
// cmp_flag_pipe: two-stage CMP/CMN/TST/TEQ unit producing registered NZCV flags
// and a condition-code verdict, with valid/ready on both sides.
module cmp_flag_pipe #(
  parameter int         WIDTH    = 32,
  parameter logic [1:0] CV_RESET = 2'b00
) (
  input logic       clk,
  input logic       rst_n,
  cmp_flag_if.slave bus
);
  logic             adv1, adv2, xfer;
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [1:0]       op_q, op_d, cv_q, cv_d;
  logic [3:0]       cond_q, cond_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, bb, r, result_q, result_d;
  logic [WIDTH:0]   sum;
  logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d, pass_q, pass_d;
  logic             nf, zf, cf, vf;
  logic [15:0]      ctab;
  always_comb begin
    adv2 = !s2_valid_q | bus.out_ready;
    adv1 = !s1_valid_q | adv2;
    xfer = s1_valid_q & adv2;
    // CMP and CMN share one adder: CMP inverts b and injects the carry-in
    bb   = op_q[0] ? b_q : ~b_q;
    sum  = {1'b0, a_q} + {1'b0, bb} + {{WIDTH{1'b0}}, ~op_q[0]};
    r    = op_q[1] ? (op_q[0] ? a_q ^ b_q : a_q & b_q) : sum[WIDTH-1:0];
    nf   = r[WIDTH-1];
    zf   = r == '0;
    cf   = op_q[1] ? cv_q[1] : sum[WIDTH];
    vf   = op_q[1] ? cv_q[0] : (a_q[WIDTH-1] == bb[WIDTH-1]) & (nf != a_q[WIDTH-1]);
    ctab = {1'b0, 1'b1, zf | (nf != vf), !zf & (nf == vf), nf != vf, nf == vf,
            !cf | zf, cf & !zf, !vf, vf, !nf, nf, !cf, cf, !zf, zf};
    s1_valid_d = adv1 ? bus.in_valid : s1_valid_q;
    {op_d, a_d, b_d, cond_d} = (adv1 & bus.in_valid) ? {bus.op, bus.a, bus.b, bus.cond}
                                                     : {op_q, a_q, b_q, cond_q};
    s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    {result_d, n_d, z_d, c_d, v_d, pass_d} = xfer ? {r, nf, zf, cf, vf, ctab[cond_q]}
                                                  : {result_q, n_q, z_q, c_q, v_q, pass_q};
    // shadow follows program order, so it updates on issue into S2, not on consume
    cv_d = (xfer & !op_q[1]) ? {cf, vf} : cv_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cond_q     <= '0;
      result_q   <= '0;
      n_q        <= 1'b0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      pass_q     <= 1'b0;
      cv_q       <= CV_RESET;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cond_q     <= cond_d;
      result_q   <= result_d;
      n_q        <= n_d;
      z_q        <= z_d;
      c_q        <= c_d;
      v_q        <= v_d;
      pass_q     <= pass_d;
      cv_q       <= cv_d;
    end
  end
  assign bus.in_ready  = adv1;
  assign bus.out_valid = s2_valid_q;
  assign bus.result    = result_q;
  assign bus.n         = n_q;
  assign bus.z         = z_q;
  assign bus.c         = c_q;
  assign bus.v         = v_q;
  assign bus.cond_pass = pass_q;
endmodule

// File: tb/tb_cmp_flag_pipe.sv
// tb_cmp_flag_pipe: directed and random stimulus for cmp_flag_pipe, scored
// against an arithmetic reference model with an in-order expectation queue.
module tb_cmp_flag_pipe;
  localparam int         W    = 32;
  localparam logic [1:0] CV_R = 2'b10;
  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  f;
    logic        p;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         total = 0, bad = 0, cons = 0;
  logic       acc_f;
  logic [1:0] cv_m = CV_R;
  exp_t       sb[$];
  cmp_flag_if #(.WIDTH(W)) bus();
  cmp_flag_pipe #(.WIDTH(W), .CV_RESET(CV_R)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t obs();
    return {bus.result, bus.n, bus.z, bus.c, bus.v, bus.cond_pass};
  endfunction
  function automatic exp_t model(logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [3:0] cond);
    longint      s;
    logic [32:0] u;
    logic [31:0] r;
    logic        n, z, c, v, p;
    c = cv_m[1];
    v = cv_m[0];
    case (op)
      2'd0: begin
        r = a - b;
        c = a >= b;
        s = longint'($signed(a)) - longint'($signed(b));
        v = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      2'd1: begin
        r = a + b;
        u = {1'b0, a} + {1'b0, b};
        c = u[32];
        s = longint'($signed(a)) + longint'($signed(b));
        v = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      2'd2: r = a & b;
      default: r = a ^ b;
    endcase
    if (!op[1]) cv_m = {c, v};
    n = r[31];
    z = r == 32'd0;
    case (cond)
      4'h0: p = z;
      4'h1: p = !z;
      4'h2: p = c;
      4'h3: p = !c;
      4'h4: p = n;
      4'h5: p = !n;
      4'h6: p = v;
      4'h7: p = !v;
      4'h8: p = c && !z;
      4'h9: p = !c || z;
      4'hA: p = n == v;
      4'hB: p = n != v;
      4'hC: p = !z && n == v;
      4'hD: p = z || n != v;
      4'hE: p = 1'b1;
      default: p = 1'b0;
    endcase
    return {r, n, z, c, v, p};
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction
  task automatic put(logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [3:0] cond);
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.cond = cond;
  endtask
  task automatic cycle();
    #1;
    acc_f = bus.in_valid & bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      cons++;
      if (sb.size() == 0) chk("spurious_out", 64'd1, 64'd0);
      else chk("scoreboard", obs(), sb.pop_front());
    end
    if (acc_f) sb.push_back(model(bus.op, bus.a, bus.b, bus.cond));
    @(negedge clk);
  endtask
  task automatic directed(string tag, logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [3:0] cond,
                          logic [31:0] er, logic [3:0] ef, logic ep);
    int lat = 1;
    bus.out_ready = 1'b1;
    put(op, a, b, cond);
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    chk({tag, "_acc"}, 64'(acc_f), 64'd1);
    while (!bus.out_valid && lat < 8) begin
      cycle();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd2);
    chk(tag, obs(), {er, ef, ep});
    cycle();
  endtask
  logic [1:0]  bop[4];
  logic [31:0] ba[4], bbv[4];
  logic [3:0]  bc[4];
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int j, c0, k;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    put(2'd0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_outs", obs(), 64'd0);
    rst_n = 1'b1;
    cycle();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    directed("cmp_gt", 2'd0, 32'd5, 32'd3, 4'hC, 32'd2, 4'b0010, 1'b1);
    directed("cmp_lt", 2'd0, 32'h8000_0000, 32'd1, 4'hB, 32'h7FFF_FFFF, 4'b0011, 1'b1);
    directed("cmn_wrap", 2'd1, 32'hFFFF_FFFF, 32'd1, 4'hE, 32'd0, 4'b0110, 1'b1);
    directed("cmp_cc", 2'd0, 32'd3, 32'd5, 4'h3, 32'hFFFF_FFFE, 4'b1000, 1'b1);
    directed("cmp_cs", 2'd0, 32'd3, 32'd5, 4'h2, 32'hFFFF_FFFE, 4'b1000, 1'b0);
    put(2'd0, 32'd5, 32'd3, 4'hE);
    bus.in_valid = 1'b1;
    cycle();
    put(2'd2, 32'hF0, 32'h0F, 4'h2);
    cycle();
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 8) begin
      cycle();
      k++;
    end
    cycle();
    chk("tst_b2b_valid", 64'(bus.out_valid), 64'd1);
    chk("tst_b2b", obs(), {32'd0, 4'b0110, 1'b1});
    cycle();
    rst_n = 1'b0;
    #1;
    sb.delete();
    cv_m = CV_R;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    directed("teq_rst", 2'd3, 32'h8000_0001, 32'h8000_0001, 4'h0, 32'd0, {2'b01, CV_R}, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bop[i] = 2'($urandom_range(0, 3));
      ba[i] = pick();
      bbv[i] = pick();
      bc[i] = 4'($urandom_range(0, 15));
    end
    bus.out_ready = 1'b0;
    j = 0;
    for (int t = 0; t < 6; t++) begin
      put(bop[j < 4 ? j : 3], ba[j < 4 ? j : 3], bbv[j < 4 ? j : 3], bc[j < 4 ? j : 3]);
      bus.in_valid = j < 4;
      cycle();
      if (acc_f) j++;
    end
    chk("stall_accepts", 64'(j), 64'd2);
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
    chk("stall_hold", obs(), sb.size() > 0 ? sb[0] : '0);
    bus.out_ready = 1'b1;
    c0 = cons;
    for (int t = 0; t < 4; t++) begin
      put(bop[j < 4 ? j : 3], ba[j < 4 ? j : 3], bbv[j < 4 ? j : 3], bc[j < 4 ? j : 3]);
      bus.in_valid = j < 4;
      cycle();
      if (acc_f) j++;
    end
    bus.in_valid = 1'b0;
    chk("stall_consec", 64'(cons - c0), 64'd4);
    chk("stall_empty", 64'(sb.size()), 64'd0);
    bus.out_ready = 1'b0;
    put(2'd0, pick(), pick(), 4'h1);
    bus.in_valid = 1'b1;
    cycle();
    put(2'd1, pick(), pick(), 4'h4);
    cycle();
    bus.in_valid = 1'b0;
    chk("mid_full", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_outs", obs(), 64'd0);
    sb.delete();
    cv_m = CV_R;
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    directed("cmp_eq_after_rst", 2'd0, 32'd7, 32'd7, 4'h0, 32'd0, 4'b0110, 1'b1);
    for (int t = 0; t < 3; t++) begin
      chk("no_stale", 64'(bus.out_valid), 64'd0);
      cycle();
    end
    for (int t = 0; t < 400; t++) begin
      bus.in_valid = $urandom_range(0, 3) != 0;
      bus.out_ready = $urandom_range(0, 2) != 0;
      put(2'($urandom_range(0, 3)), pick(), $urandom_range(0, 3) == 0 ? bus.a : pick(),
          4'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) bus.b = bus.a;
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 6; t++) cycle();
    chk("drain_empty", 64'(sb.size()), 64'd0);
    chk("drain_idle", 64'(bus.out_valid), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
